debug_loader: RTL and testbench

Host-side debug/program loader for the 16-bit multicycle CPU test system. It accepts a stream of 16-bit command and payload words over a valid/ready handshake. From that stream it drives the system's memory-load, register-load, reset-PC and run-enable (`test`) inputs. It sits directly upstream of the system top, and its outputs connect one-to-one to that top's debug inputs.

---
 rtl/debug_loader_pkg.sv | 27 ++
 rtl/run_timer.sv | 39 +++
 rtl/debug_loader.sv | 164 ++++++++++++++++
 tb/tb_debug_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_loader_pkg.sv
// rtl/debug_loader_pkg.sv - opcodes, command field slices and FSM states for debug_loader
package debug_loader_pkg;

  localparam logic [3:0] OP_MEMLOAD = 4'h1;
  localparam logic [3:0] OP_REGLOAD = 4'h2;
  localparam logic [3:0] OP_SETPC   = 4'h3;
  localparam logic [3:0] OP_RUN     = 4'h4;
  localparam logic [3:0] OP_HALT    = 4'h5;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int ARG_MSB = 11;
  localparam int ARG_LSB = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_MEM_BASE,
    S_MEM_DATA,
    S_MEM_WR,
    S_REG_DATA,
    S_REG_WR,
    S_PC_DATA,
    S_PC_RST,
    S_RUN
  } state_t;

endpackage

// File: rtl/run_timer.sv
// rtl/run_timer.sv - loadable run-enable down-counter; free-run until halt when flagged
module run_timer #(
  parameter int RUN_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [RUN_W-1:0] value,
  input  logic             free,
  input  logic             halt,
  output logic             test,
  output logic             expiring
);

  logic [RUN_W-1:0] cnt;
  logic             free_q;

  // high in the last counted cycle so the loader can leave RUN on the same edge
  assign expiring = test & ~free_q & (cnt == RUN_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      test   <= 1'b0;
      cnt    <= '0;
      free_q <= 1'b0;
    end else if (halt) begin
      test <= 1'b0;
    end else if (load) begin
      test   <= 1'b1;
      cnt    <= value;
      free_q <= free;
    end else if (expiring) begin
      test <= 1'b0;
    end else if (test && !free_q) begin
      cnt <= cnt - RUN_W'(1);
    end
  end

endmodule

// File: rtl/debug_loader.sv
// rtl/debug_loader.sv - command-stream debug/program loader; DEBUG_LOADER_CHECKSUM_EN adds checksum port
module debug_loader
  import debug_loader_pkg::*;
#(
  parameter int RUN_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        memoryoperation,
  output logic        memorywrite,
  output logic [15:0] memaddress,
  output logic [15:0] memwritedata,
  output logic        registeroperation,
  output logic        registerwrite,
  output logic [3:0]  registeraddress,
  output logic [15:0] regwritedata,
  output logic [15:0] resetpc,
  output logic        core_reset,
  output logic        test,
  output logic        err
`ifdef DEBUG_LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  state_t      state, state_nx;
  logic        ready_en;
  logic        take;
  logic [3:0]  opc;
  logic [11:0] arg;
  logic [12:0] mem_left;
  logic        pc_second;
  logic        run_load, run_halt, run_expiring;

  assign opc  = in_data[OPC_MSB:OPC_LSB];
  assign arg  = in_data[ARG_MSB:ARG_LSB];
  assign take = in_valid & in_ready;

  assign memorywrite       = (state == S_MEM_WR);
  assign memoryoperation   = (state == S_MEM_DATA) || (state == S_MEM_WR);
  assign registerwrite     = (state == S_REG_WR);
  assign registeroperation = (state == S_REG_DATA) || (state == S_REG_WR);
  assign core_reset        = (state == S_PC_RST);

  // ready_en keeps in_ready low for the first cycle after reset release
  always_comb begin
    in_ready = 1'b0;
    if (ready_en) begin
      case (state)
        S_IDLE, S_MEM_BASE, S_MEM_DATA, S_REG_DATA, S_PC_DATA, S_RUN: in_ready = 1'b1;
        default: in_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    run_load = 1'b0;
    run_halt = 1'b0;
    case (state)
      S_IDLE: begin
        if (take) begin
          case (opc)
            OP_MEMLOAD: state_nx = S_MEM_BASE;
            OP_REGLOAD: state_nx = S_REG_DATA;
            OP_SETPC:   state_nx = S_PC_DATA;
            OP_RUN: begin
              state_nx = S_RUN;
              run_load = 1'b1;
            end
            default: state_nx = S_IDLE;
          endcase
        end
      end
      S_MEM_BASE: if (take) state_nx = S_MEM_DATA;
      S_MEM_DATA: if (take) state_nx = S_MEM_WR;
      S_MEM_WR:   state_nx = (mem_left == 13'd1) ? S_IDLE : S_MEM_DATA;
      S_REG_DATA: if (take) state_nx = S_REG_WR;
      S_REG_WR:   state_nx = S_IDLE;
      S_PC_DATA:  if (take) state_nx = S_PC_RST;
      S_PC_RST:   if (pc_second) state_nx = S_IDLE;
      S_RUN: begin
        // HALT wins over a count expiring on the same edge
        if (take && opc == OP_HALT) begin
          run_halt = 1'b1;
          state_nx = S_IDLE;
        end else if (run_expiring) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      ready_en        <= 1'b0;
      mem_left        <= '0;
      pc_second       <= 1'b0;
      memaddress      <= '0;
      memwritedata    <= '0;
      registeraddress <= '0;
      regwritedata    <= '0;
      resetpc         <= '0;
      err             <= 1'b0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
      checksum        <= '0;
`endif
    end else begin
      state    <= state_nx;
      ready_en <= 1'b1;
      case (state)
        S_IDLE: begin
          if (take) begin
            if (opc == OP_MEMLOAD) begin
              mem_left <= (arg == 12'd0) ? 13'd4096 : {1'b0, arg};
`ifdef DEBUG_LOADER_CHECKSUM_EN
              checksum <= '0;
`endif
            end
            if (opc == OP_REGLOAD) registeraddress <= arg[3:0];
            if (opc == 4'h0 || opc > OP_HALT) err <= 1'b1;
          end
        end
        S_MEM_BASE: if (take) memaddress <= in_data;
        S_MEM_DATA: if (take) memwritedata <= in_data;
        S_MEM_WR: begin
          memaddress <= memaddress + 16'd1;
          mem_left   <= mem_left - 13'd1;
`ifdef DEBUG_LOADER_CHECKSUM_EN
          checksum   <= checksum + memwritedata;
`endif
        end
        S_REG_DATA: if (take) regwritedata <= in_data;
        S_PC_DATA: begin
          if (take) begin
            resetpc   <= in_data;
            pc_second <= 1'b0;
          end
        end
        S_PC_RST: pc_second <= 1'b1;
        S_RUN: if (take && opc != OP_HALT) err <= 1'b1;
        default: ;
      endcase
    end
  end

  run_timer #(.RUN_W(RUN_W)) u_run_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (run_load),
    .value    (RUN_W'(arg)),
    .free     (arg == 12'd0),
    .halt     (run_halt),
    .test     (test),
    .expiring (run_expiring)
  );

endmodule

// File: tb/tb_debug_loader.sv
// tb/tb_debug_loader.sv - directed table-driven bench for debug_loader
module tb_debug_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, memoryoperation, memorywrite, registeroperation, registerwrite;
  logic        core_reset, test, err;
  logic [15:0] memaddress, memwritedata, regwritedata, resetpc;
  logic [3:0]  registeraddress;
`ifdef DEBUG_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  debug_loader #(.RUN_W(12)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .memoryoperation   (memoryoperation),
    .memorywrite       (memorywrite),
    .memaddress        (memaddress),
    .memwritedata      (memwritedata),
    .registeroperation (registeroperation),
    .registerwrite     (registerwrite),
    .registeraddress   (registeraddress),
    .regwritedata      (regwritedata),
    .resetpc           (resetpc),
    .core_reset        (core_reset),
    .test              (test),
    .err               (err)
`ifdef DEBUG_LOADER_CHECKSUM_EN
    ,
    .checksum          (checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [79:0] all_out;
  assign all_out = {4'h0, in_ready, memoryoperation, memorywrite, memaddress, memwritedata,
                    registeroperation, registerwrite, registeraddress, regwritedata,
                    resetpc, core_reset, test, err};

  int vecs = 0, errs = 0;
  int cyc = 0, wr_pulses = 0, test_cycles = 0, overlap = 0, ready_drop = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (memorywrite) wr_pulses++;
    if (test) test_cycles++;
    if (test && (memorywrite || registerwrite || core_reset)) overlap++;
    if (test && !in_ready) ready_drop++;
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    bit ok = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      vecs++;
      errs++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 for word %h", w);
    end else begin
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_test_low();
    for (int k = 0; k < 5000 && test; k++) step();
    chk("test_fell", test, 1'b0);
  endtask

  typedef enum int {K_REG, K_PC, K_RUN} kind_t;
  typedef struct {
    kind_t       kind;
    logic [11:0] arg;
    logic [15:0] payload;
    logic [15:0] exp_a;
    logic [15:0] exp_d;
  } vec_t;

  vec_t        tbl[8];
  logic [15:0] md[3];
  logic [15:0] ma[3];
  int          t0, w0, last_cyc;

  initial begin
    tbl[0] = '{K_REG, 12'h005, 16'h1234, 16'h0005, 16'h1234};
    tbl[1] = '{K_REG, 12'h00F, 16'hFFFF, 16'h000F, 16'hFFFF};
    tbl[2] = '{K_REG, 12'h0A7, 16'h0001, 16'h0007, 16'h0001};
    tbl[3] = '{K_PC,  12'h000, 16'h0040, 16'h0000, 16'h0040};
    tbl[4] = '{K_PC,  12'h000, 16'hBEEF, 16'h0000, 16'hBEEF};
    tbl[5] = '{K_RUN, 12'h00A, 16'h0000, 16'h0000, 16'd10};
    tbl[6] = '{K_RUN, 12'h001, 16'h0000, 16'h0000, 16'd1};
    tbl[7] = '{K_RUN, 12'h003, 16'h0000, 16'h0000, 16'd3};
    md = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    ma = '{16'h0010, 16'h0011, 16'h0012};

    // reset state and in_ready release timing
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", all_out, 80'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ready_after_release", in_ready, 1'b0);
    step();
    chk("ready_rise", in_ready, 1'b1);

    // MEMLOAD 3 words at 0x0010
    send(16'h1003);
    chk("memop_before_base", memoryoperation, 1'b0);
    send(16'h0010);
    chk("memop_after_base", memoryoperation, 1'b1);
    w0 = wr_pulses;
    last_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      send(md[k]);
      chk("mem_strobe", memorywrite, 1'b1);
      chk("mem_addr", memaddress, ma[k]);
      chk("mem_data", memwritedata, md[k]);
      chk("mem_op", memoryoperation, 1'b1);
      if (k > 0) chk("mem_spacing", cyc - last_cyc, 2);
      last_cyc = cyc;
    end
    step();
    chk("memop_end", {memoryoperation, memorywrite}, 2'b00);
    chk("mem_pulses", wr_pulses - w0, 3);
`ifdef DEBUG_LOADER_CHECKSUM_EN
    chk("checksum", checksum, 16'h3331);
`endif

    // MEMLOAD 2 words across the address wrap
    send(16'h1002);
    send(16'hFFFF);
    send(16'h1111);
    chk("wrap_addr0", memaddress, 16'hFFFF);
    send(16'h2222);
    chk("wrap_addr1", memaddress, 16'h0000);
    chk("wrap_data1", memwritedata, 16'h2222);
    step();
    chk("wrap_memop_end", memoryoperation, 1'b0);

    // table: REGLOAD, SETPC, counted RUN
    for (int i = 0; i < 8; i++) begin
      case (tbl[i].kind)
        K_REG: begin
          send({4'h2, tbl[i].arg});
          chk("regop_pre", {registeroperation, registerwrite}, 2'b10);
          send(tbl[i].payload);
          chk("reg_strobe", {registeroperation, registerwrite}, 2'b11);
          chk("reg_addr", registeraddress, tbl[i].exp_a);
          chk("reg_data", regwritedata, tbl[i].exp_d);
          step();
          chk("reg_end", {registeroperation, registerwrite}, 2'b00);
        end
        K_PC: begin
          send(16'h3000);
          send(tbl[i].payload);
          chk("pc_rst1", {core_reset, in_ready}, 2'b10);
          chk("pc_value", resetpc, tbl[i].exp_d);
          step();
          chk("pc_rst2", {core_reset, in_ready}, 2'b10);
          step();
          chk("pc_done", {core_reset, in_ready}, 2'b01);
          chk("pc_held", resetpc, tbl[i].exp_d);
        end
        default: begin
          t0 = test_cycles;
          send({4'h4, tbl[i].arg});
          chk("run_rise", test, 1'b1);
          wait_test_low();
          chk("run_cycles", test_cycles - t0, int'(tbl[i].exp_d));
        end
      endcase
    end

    // free run stopped by HALT after 25 cycles
    send(16'h4000);
    repeat (25) step();
    chk("free_run_high", test, 1'b1);
    send(16'h5000);
    chk("halt_drop", test, 1'b0);
    chk("no_err_yet", err, 1'b0);

    // bad opcode in IDLE, then MEMLOAD dropped during a counted run
    send(16'hF123);
    chk("bad_op_err", {err, in_ready}, 2'b11);
    t0 = test_cycles;
    send(16'h4005);
    send(16'h1003);
    chk("run_drop_memop", memoryoperation, 1'b0);
    wait_test_low();
    chk("run_unaffected", test_cycles - t0, 5);
    chk("err_sticky", err, 1'b1);

    // reset after first of four MEMLOAD writes
    send(16'h1004);
    send(16'h0100);
    send(16'h1111);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midburst_reset", all_out, 80'h0);
    w0 = wr_pulses;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    send(16'h2003);
    send(16'h5A5A);
    chk("post_reset_reg", {registerwrite, registeraddress, regwritedata}, {1'b1, 4'h3, 16'h5A5A});
    chk("no_partial_write", wr_pulses - w0, 0);
    chk("err_cleared", err, 1'b0);

    chk("strobe_test_overlap", overlap, 0);
    chk("ready_in_run", ready_drop, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
